// File: rtl/red_pitaya_fads_sort_sched_if.sv
// Classifier-side request/configuration inputs and sort-trigger/statistics outputs
// of the FADS sort-pulse scheduler.
interface red_pitaya_fads_sort_sched_if #(
    parameter int QSZ = 3,
    parameter int TW  = 32
);
    logic          req_i;
    logic          enable_i;
    logic          flush_i;
    logic [TW-1:0] cfg_delay_i;
    logic [TW-1:0] cfg_duration_i;
    logic          sort_trig_o;
    logic [QSZ:0]  level_o;
    logic          full_o;
    logic [TW-1:0] accepted_cnt_o;
    logic [TW-1:0] dropped_cnt_o;
    logic [TW-1:0] merged_cnt_o;
    logic [TW-1:0] fired_cnt_o;

    modport slave (
        input  req_i, enable_i, flush_i, cfg_delay_i, cfg_duration_i,
        output sort_trig_o, level_o, full_o,
               accepted_cnt_o, dropped_cnt_o, merged_cnt_o, fired_cnt_o
    );

    modport master (
        output req_i, enable_i, flush_i, cfg_delay_i, cfg_duration_i,
        input  sort_trig_o, level_o, full_o,
               accepted_cnt_o, dropped_cnt_o, merged_cnt_o, fired_cnt_o
    );
endinterface

// File: rtl/red_pitaya_fads_sort_sched.sv
// Sort-pulse scheduler: timestamps positive-droplet requests, queues them with their
// travel delay and issues due entries in order onto one merged sort-trigger pulse.
module red_pitaya_fads_sort_sched #(
    parameter int QSZ = 3,
    parameter int TW  = 32
) (
    input  logic adc_clk_i,
    input  logic adc_rst_i,
    red_pitaya_fads_sort_sched_if.slave bus
);
    localparam int            DEPTH = 1 << QSZ;
    // Request edge -> queue write -> fire edge: two edges of pipeline on top of the delay.
    localparam logic [TW-1:0] LAT   = TW'(2);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t        state, state_next;
    logic [TW-1:0] remain, remain_next;
    logic [TW-1:0] ts;
    logic [TW-1:0] due_mem [DEPTH];
    logic [QSZ-1:0] wr_ptr, rd_ptr;
    logic [QSZ:0]  level;
    logic [TW-1:0] age;
    logic [TW-1:0] accepted_cnt, dropped_cnt, merged_cnt, fired_cnt;
    logic          full, head_due, fire, push_req, push, drop, merge;

    assign full     = (level == (QSZ+1)'(DEPTH));
    // Wrap-safe: the head is due once the timestamp has passed it by less than half a period.
    assign age      = ts - due_mem[rd_ptr];
    assign head_due = (level != '0) && ($signed(age) >= 0);
    assign fire     = head_due && !bus.flush_i;
    assign push_req = bus.req_i && bus.enable_i && !bus.flush_i;
    assign push     = push_req && (!full || fire);
    assign drop     = push_req && !push;

    always_comb begin
        state_next  = state;
        remain_next = remain;
        merge       = 1'b0;
        if (bus.flush_i) begin
            state_next = IDLE;
        end else if (fire && (bus.cfg_duration_i != '0)) begin
            state_next  = PULSE;
            remain_next = bus.cfg_duration_i;
            merge       = (state == PULSE);
        end else if (state == PULSE) begin
            if (remain == TW'(1)) state_next = IDLE;
            else                  remain_next = remain - TW'(1);
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            ts           <= '0;
            state        <= IDLE;
            remain       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
            merged_cnt   <= '0;
            fired_cnt    <= '0;
        end else begin
            ts     <= ts + TW'(1);
            state  <= state_next;
            remain <= remain_next;
            if (bus.flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + QSZ'(1);
                if (fire) rd_ptr <= rd_ptr + QSZ'(1);
                level <= level + (QSZ+1)'(push) - (QSZ+1)'(fire);
            end
            accepted_cnt <= accepted_cnt + TW'(push);
            dropped_cnt  <= dropped_cnt + TW'(drop);
            merged_cnt   <= merged_cnt + TW'(merge);
            fired_cnt    <= fired_cnt + TW'(fire);
        end
    end

    // NOTE: storage is not reset; entries are only read once the level says they were written.
    always_ff @(posedge adc_clk_i) begin
        if (push) due_mem[wr_ptr] <= ts + bus.cfg_delay_i + LAT;
    end

    assign bus.sort_trig_o    = (state == PULSE);
    assign bus.level_o        = level;
    assign bus.full_o         = full;
    assign bus.accepted_cnt_o = accepted_cnt;
    assign bus.dropped_cnt_o  = dropped_cnt;
    assign bus.merged_cnt_o   = merged_cnt;
    assign bus.fired_cnt_o    = fired_cnt;
endmodule

// File: tb/tb_red_pitaya_fads_sort_sched.sv
// Scoreboard bench: an absolute-time model predicts every cycle's outputs, a monitor
// compares them; a narrow-timestamp instance exercises the timestamp wrap.
module tb_red_pitaya_fads_sort_sched;
    localparam int QSZ   = 3;
    localparam int TW    = 32;
    localparam int DEPTH = 1 << QSZ;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    always #5 clk = ~clk;

    red_pitaya_fads_sort_sched_if #(.QSZ(QSZ), .TW(TW)) bus ();
    red_pitaya_fads_sort_sched #(.QSZ(QSZ), .TW(TW)) dut (
        .adc_clk_i(clk), .adc_rst_i(rst), .bus(bus)
    );

    red_pitaya_fads_sort_sched_if #(.QSZ(QSZ), .TW(8)) sbus ();
    red_pitaya_fads_sort_sched #(.QSZ(QSZ), .TW(8)) dut_s (
        .adc_clk_i(clk), .adc_rst_i(rst_s), .bus(sbus)
    );

    typedef struct {
        logic        trig;
        logic [31:0] level;
        logic        full;
        logic [31:0] acc;
        logic [31:0] drop;
        logic [31:0] merged;
        logic [31:0] fired;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_s = 1'b0;

    // Reference model: absolute cycle numbers, no wrap, pulse as "last high cycle".
    longint      cyc = 0;
    longint      mq[$];
    longint      pulse_end = -1;
    logic [31:0] m_acc = 0, m_drop = 0, m_merged = 0, m_fired = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input logic r, input logic req, input logic en, input logic fl,
                        input logic [31:0] d, input logic [31:0] n);
        exp_t   e;
        logic   fire_now, active;
        rst                = r;
        bus.req_i          = req;
        bus.enable_i       = en;
        bus.flush_i        = fl;
        bus.cfg_delay_i    = d;
        bus.cfg_duration_i = n;
        @(posedge clk);
        if (r) begin
            mq.delete();
            pulse_end = cyc - 1;
            m_acc = 0; m_drop = 0; m_merged = 0; m_fired = 0;
        end else if (fl) begin
            mq.delete();
            pulse_end = cyc - 1;
        end else begin
            fire_now = (mq.size() > 0) && (mq[0] <= cyc);
            active   = (pulse_end >= cyc - 1);
            if (fire_now) begin
                void'(mq.pop_front());
                m_fired++;
                if (n != 0) begin
                    if (active) m_merged++;
                    pulse_end = cyc + longint'(n) - 1;
                end
            end
            if (req && en) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(cyc + longint'(d) + 2);
                    m_acc++;
                end else begin
                    m_drop++;
                end
            end
        end
        e.trig   = (pulse_end >= cyc);
        e.level  = 32'(mq.size());
        e.full   = (mq.size() == DEPTH);
        e.acc    = m_acc;
        e.drop   = m_drop;
        e.merged = m_merged;
        e.fired  = m_fired;
        sb.push_back(e);
        cyc++;
        #1;
    endtask

    task automatic idle(input int k, input logic [31:0] n);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd10, n);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sort_trig", 32'(bus.sort_trig_o), 32'(e.trig));
                check("level",     32'(bus.level_o),     e.level);
                check("full",      32'(bus.full_o),      32'(e.full));
                check("accepted",  bus.accepted_cnt_o,   e.acc);
                check("dropped",   bus.dropped_cnt_o,    e.drop);
                check("merged",    bus.merged_cnt_o,     e.merged);
                check("fired",     bus.fired_cnt_o,      e.fired);
            end
        end
    end

    // Narrow instance: ts runs 0,1,2.. after reset; request at ts=251, delay 20 -> due wraps to 17.
    initial begin : wrap_test
        rst_s               = 1'b1;
        sbus.req_i          = 1'b0;
        sbus.enable_i       = 1'b1;
        sbus.flush_i        = 1'b0;
        sbus.cfg_delay_i    = 8'd20;
        sbus.cfg_duration_i = 8'd3;
        repeat (3) @(posedge clk);
        #1 rst_s = 1'b0;
        for (int j = 0; j <= 290; j++) begin
            sbus.req_i = (j == 251);
            @(posedge clk);
            #1;
            if (j >= 240)
                check("wrap_trig", 32'(sbus.sort_trig_o), 32'((j >= 273) && (j <= 275)));
        end
        check("wrap_fired",    32'(sbus.fired_cnt_o),    32'd1);
        check("wrap_accepted", 32'(sbus.accepted_cnt_o), 32'd1);
        done_s = 1'b1;
    end

    initial begin : driver
        longint t0;
        logic [31:0] dur;
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);

        // Single request, delay 10, duration 5.
        idle(20, 5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd10, 32'd5);
        idle(30, 5);

        // Three requests 3 cycles apart merge into one pulse.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd50, 32'd20);
        idle(2, 20);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd50, 32'd20);
        idle(2, 20);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd50, 32'd20);
        idle(100, 20);

        // Ten back-to-back requests into an 8-deep queue, then a push on the first pop.
        t0 = cyc;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd1000, 32'd3);
        while (cyc < t0 + 1002) idle(1, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd1000, 32'd3);
        idle(1030, 3);

        // Zero duration at fire.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
        idle(15, 0);

        // Requests ignored while disabled.
        for (int i = 0; i < 6; i++) step(1'b0, i[0], 1'b0, 1'b0, 32'd3, 32'd4);
        idle(10, 4);

        // Flush mid-pulse with four entries still queued (same-cycle request discarded).
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd20, 32'd30);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'(40 + 10 * i), 32'd30);
        idle(25, 30);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 32'd30);
        idle(120, 30);

        // Randomised traffic with changing duration, enable and occasional flush.
        dur = 32'd4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dur = $urandom_range(0, 12);
            step(1'b0, $urandom_range(0, 5) == 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 399) == 0, 32'($urandom_range(0, 40)), dur);
        end
        idle(80, 4);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("wrap_test_done",     32'(done_s),    32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
